// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen
//
// Produces bursts of enable pulses with exact lengths. A command sets the
// high length, the low gap and the number of pulses. enable_out then stays
// high for exactly high_len cycles per pulse, so a downstream cycle counter
// reads back the commanded length. This is used for self-test and
// calibration of the counting chain.
//
// Ports:
//   clk           sole clock
//   rst           asynchronous, active-high reset
//   cmd_valid     command offered
//   cmd_ready     command accepted when cmd_valid && cmd_ready at a rising edge
//   cmd_high_len  cycles enable_out is high per pulse
//   cmd_low_len   low gap between pulses (0 behaves as 1)
//   cmd_pulses    number of pulses in the burst
//   abort         terminate the active burst
//   enable_out    generated enable (registered)
//   busy          burst in progress (registered)
//   done          one-cycle pulse on normal burst completion
//   pulses_sent   completed high phases in the current/last burst
module enable_pulse_gen #(
  parameter int COUNTER_WIDTH = 32,
  parameter int BURST_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COUNTER_WIDTH-1:0] cmd_high_len,
  input  logic [COUNTER_WIDTH-1:0] cmd_low_len,
  input  logic [BURST_WIDTH-1:0]   cmd_pulses,
  input  logic                     abort,
  output logic                     enable_out,
  output logic                     busy,
  output logic                     done,
  output logic [BURST_WIDTH-1:0]   pulses_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [COUNTER_WIDTH-1:0] phase_cnt_reg, phase_cnt_next;
  logic [COUNTER_WIDTH-1:0] high_len_reg, high_len_next;
  logic [COUNTER_WIDTH-1:0] low_len_reg, low_len_next;
  logic [BURST_WIDTH-1:0]   pulses_reg, pulses_next;
  logic [BURST_WIDTH-1:0]   sent_next;
  logic [BURST_WIDTH-1:0]   sent_plus_one;
  logic [COUNTER_WIDTH-1:0] gap_len;
  logic                     enable_next;
  logic                     busy_next;
  logic                     done_next;
  logic                     accept;
  logic                     degenerate;
  logic                     phase_end;
  logic                     last_pulse;

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign cmd_ready  = (state_reg == IDLE) && !abort && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign degenerate = (cmd_high_len == '0) || (cmd_pulses == '0);

  // The phase counter holds the number of cycles left in the current phase,
  // including the present one, so a value of 1 marks the final cycle.
  assign phase_end = (phase_cnt_reg == COUNTER_WIDTH'(1));

  // pulses_sent is always below pulses_reg while in HIGH, so the +1 cannot wrap.
  assign sent_plus_one = pulses_sent + BURST_WIDTH'(1);
  assign last_pulse    = (sent_plus_one >= pulses_reg);

  // A zero gap is stretched to one cycle so adjacent pulses never merge.
  assign gap_len = (low_len_reg == '0) ? COUNTER_WIDTH'(1) : low_len_reg;

  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    high_len_next  = high_len_reg;
    low_len_next   = low_len_reg;
    pulses_next    = pulses_reg;
    sent_next      = pulses_sent;
    enable_next    = 1'b0;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          high_len_next = cmd_high_len;
          low_len_next  = cmd_low_len;
          pulses_next   = cmd_pulses;
          sent_next     = '0;
          if (degenerate) begin
            // Nothing to emit: report completion on the next cycle.
            done_next = 1'b1;
          end else begin
            state_next     = HIGH;
            phase_cnt_next = cmd_high_len;
            enable_next    = 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          // Abort wins over a phase ending in the same cycle; the
          // interrupted pulse is not counted.
          state_next = IDLE;
        end else if (phase_end) begin
          sent_next = sent_plus_one;
          if (last_pulse) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next     = LOW;
            phase_cnt_next = gap_len;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg - COUNTER_WIDTH'(1);
          enable_next    = 1'b1;
        end
      end

      LOW: begin
        if (abort) begin
          state_next = IDLE;
        end else if (phase_end) begin
          state_next     = HIGH;
          phase_cnt_next = high_len_reg;
          enable_next    = 1'b1;
        end else begin
          phase_cnt_next = phase_cnt_reg - COUNTER_WIDTH'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      high_len_reg  <= '0;
      low_len_reg   <= '0;
      pulses_reg    <= '0;
      pulses_sent   <= '0;
      enable_out    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      high_len_reg  <= high_len_next;
      low_len_reg   <= low_len_next;
      pulses_reg    <= pulses_next;
      pulses_sent   <= sent_next;
      enable_out    <= enable_next;
      busy          <= busy_next;
      done          <= done_next;
    end
  end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Testbench for enable_pulse_gen. The driver pushes each accepted command
// into a queue. The monitor pops that command when the burst starts. It then
// checks every cycle of the burst against a timeline computed arithmetically
// from the command.
module tb_enable_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_high_len;
  logic [31:0] cmd_low_len;
  logic [15:0] cmd_pulses;
  logic        abort;
  logic        enable_out;
  logic        busy;
  logic        done;
  logic [15:0] pulses_sent;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int h;
    int l;
    int n;
    int a;  // abort cycle offset after accept (0 = no abort)
  } cmd_t;

  cmd_t exp_q[$];

  enable_pulse_gen #(.COUNTER_WIDTH(32), .BURST_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_high_len (cmd_high_len),
    .cmd_low_len  (cmd_low_len),
    .cmd_pulses   (cmd_pulses),
    .abort        (abort),
    .enable_out   (enable_out),
    .busy         (busy),
    .done         (done),
    .pulses_sent  (pulses_sent)
  );

  always #5 clk = ~clk;

  // Number of high phases whose last cycle lies strictly before cycle lim.
  // Cycles are numbered from 1 after the accept edge. Phase i ends at cycle
  // i*(h+g)+h.
  function automatic int completed(input int h, input int g, input int n, input int lim);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (i * (h + g) + h < lim) c++;
    end
    return c;
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic pend   = 1'b0;
  logic active = 1'b0;
  cmd_t cur;
  int   pos;

  always @(negedge clk) begin
    int   g, t, last;
    logic e_en, e_busy, e_done;
    int   e_ps;
    if (rst) begin
      pend   = 1'b0;
      active = 1'b0;
      exp_q.delete();
    end else begin
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty actual=0 entries required>=1");
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          pos    = 0;
        end
      end
      if (active) begin
        pos++;
        g = (cur.l == 0) ? 1 : cur.l;
        e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ps = 0;
        if (cur.h == 0 || cur.n == 0) begin
          last   = 1;
          e_done = 1'b1;
        end else begin
          t    = cur.n * cur.h + (cur.n - 1) * g;
          last = (cur.a > 0) ? cur.a + 1 : t + 1;
          if (pos < last) begin
            e_en   = (((pos - 1) % (cur.h + g)) < cur.h);
            e_busy = 1'b1;
            e_ps   = completed(cur.h, g, cur.n, pos);
          end else if (cur.a > 0) begin
            e_ps = completed(cur.h, g, cur.n, cur.a);
          end else begin
            e_done = 1'b1;
            e_ps   = cur.n;
          end
        end
        checks++;
        if (enable_out !== e_en || busy !== e_busy || done !== e_done ||
            pulses_sent !== 16'(e_ps)) begin
          failures++;
          $display("FAIL cycle h=%0d l=%0d n=%0d a=%0d pos=%0d actual en/busy/done/ps=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                   cur.h, cur.l, cur.n, cur.a, pos, enable_out, busy, done, pulses_sent,
                   e_en, e_busy, e_done, e_ps);
        end
        if (pos == last) begin
          active = 1'b0;
          $display("txn h=%0d l=%0d n=%0d a=%0d end_cycle=%0d pulses_sent=%0d",
                   cur.h, cur.l, cur.n, cur.a, pos, pulses_sent);
        end
      end else begin
        checks++;
        if (enable_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL idle actual en/busy/done=%b/%b/%b required=0/0/0",
                   enable_out, busy, done);
        end
      end
      if (cmd_valid && cmd_ready) pend = 1'b1;
    end
  end

  // ---------------- driver ----------------
  // Offers a command (held until accepted), records it, optionally aborts at
  // cycle offset a. Returns at posedge+1 with cmd_valid low.
  task automatic issue(input int h, input int l, input int n, input int a);
    cmd_t c;
    bit   got = 0;
    cmd_valid    = 1'b1;
    cmd_high_len = 32'(h);
    cmd_low_len  = 32'(l);
    cmd_pulses   = 16'(n);
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
      @(posedge clk);
    end
    if (!got) begin
      $display("FAIL accept_timeout actual=not_ready required=ready");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "accept timeout");
    end
    c.h = h; c.l = l; c.n = n; c.a = a;
    exp_q.push_back(c);
    #1;
    cmd_valid    = 1'b0;
    cmd_high_len = $urandom;
    cmd_low_len  = $urandom;
    cmd_pulses   = 16'($urandom);
    if (a > 0) begin
      repeat (a - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 5000 && !idle; i++) begin
      @(negedge clk);
      if (!busy && !active && exp_q.size() == 0 && !pend) idle = 1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h, l, n, a, g, t;
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_high_len = '0;
    cmd_low_len  = '0;
    cmd_pulses   = '0;
    abort        = 1'b0;

    #1;
    check1("reset_enable", enable_out, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_pulses_sent", (pulses_sent == 16'd0), 1'b1);
    check1("reset_cmd_ready", cmd_ready, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check1("ready_after_reset", cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed cases from the test plan, offered back to back.
    issue(5, 3, 1, 0);
    issue(4, 2, 3, 0);
    issue(3, 0, 2, 0);
    issue(0, 5, 7, 0);
    issue(9, 2, 0, 0);
    issue(10, 0, 1, 4);
    wait_idle();

    // A command offered together with abort in IDLE must not be accepted.
    cmd_valid    = 1'b1;
    abort        = 1'b1;
    cmd_high_len = 32'd5;
    cmd_pulses   = 16'd1;
    @(negedge clk);
    check1("abort_blocks_ready", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    check1("abort_idle_not_accepted", busy, 1'b0);
    @(posedge clk);
    #1;

    // Randomized commands, mixing back-to-back offers, gaps and aborts.
    for (int i = 0; i < 40; i++) begin
      h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      l = $urandom_range(0, 4);
      n = $urandom_range(0, 4);
      a = 0;
      if (h > 0 && n > 0 && $urandom_range(0, 3) == 0) begin
        g = (l == 0) ? 1 : l;
        t = n * h + (n - 1) * g;
        a = $urandom_range(1, t);
      end
      issue(h, l, n, a);
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Asynchronous reset in the middle of a long high phase.
    issue(100, 0, 2, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check1("async_rst_enable", enable_out, 1'b0);
    check1("async_rst_busy", busy, 1'b0);
    check1("async_rst_done", done, 1'b0);
    check1("async_rst_cmd_ready", cmd_ready, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check1("ready_after_async_rst", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    issue(2, 1, 1, 0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
